// File: rtl/glb_pkg.sv
// rtl/glb_pkg.sv - shared types and helpers for the banked ifmap global buffer
package glb_pkg;

  localparam int GLB_DATA_WIDTH = 16;

  typedef enum logic {
    GLB_FILL_IDLE = 1'b0,
    GLB_FILL_RUN  = 1'b1
  } glb_fill_state_e;

  function automatic int glb_lane_bits(input int num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

  function automatic int glb_lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/glb_lane_ram.sv
// rtl/glb_lane_ram.sv - one lane bank: true dual-port, read-first, registered holding outputs
module glb_lane_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we_a,
  input  logic                  i_re_a,
  input  logic [AW-1:0]         i_addr_a,
  input  logic [DATA_WIDTH-1:0] i_wdata_a,
  output logic [DATA_WIDTH-1:0] o_rdata_a,
  input  logic                  i_we_b,
  input  logic                  i_re_b,
  input  logic [AW-1:0]         i_addr_b,
  input  logic [DATA_WIDTH-1:0] i_wdata_b,
  output logic [DATA_WIDTH-1:0] o_rdata_b
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Port A is written last so it would win a same-address clash; the top never lets one through.
  always_ff @(posedge clk) begin
    if (i_we_b) r_mem[i_addr_b] <= i_wdata_b;
    if (i_we_a) r_mem[i_addr_a] <= i_wdata_a;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rdata_a <= '0;
      o_rdata_b <= '0;
    end else begin
      if (i_re_a) o_rdata_a <= r_mem[i_addr_a];
      if (i_re_b) o_rdata_b <= r_mem[i_addr_b];
    end
  end

endmodule

// File: rtl/ifmap_glb_banked.sv
// rtl/ifmap_glb_banked.sv - N-lane banked ifmap buffer with fill engine, forwarding and collision arbitration
module ifmap_glb_banked
  import glb_pkg::*;
#(
  parameter int DATA_WIDTH = GLB_DATA_WIDTH,
  parameter int NUM_LANES  = 4,
  parameter int MEM_DEPTH  = 64
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        fill_start,
  input  logic [$clog2(MEM_DEPTH/NUM_LANES)-1:0]      fill_base,
  input  logic [$clog2(MEM_DEPTH/NUM_LANES):0]        fill_len,
  input  logic                                        we_a,
  input  logic [NUM_LANES-1:0]                        wmask_a,
  input  logic                                        a_auto,
  input  logic [$clog2(MEM_DEPTH/NUM_LANES)-1:0]      addr_a,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]             wdata_a,
  input  logic                                        re_a,
  output logic [DATA_WIDTH*NUM_LANES-1:0]             rdata_a,
  output logic                                        rvalid_a,
  input  logic                                        we_b,
  input  logic                                        re_b,
  input  logic [$clog2(MEM_DEPTH)-1:0]                addr_b,
  input  logic [DATA_WIDTH-1:0]                       wdata_b,
  output logic [DATA_WIDTH-1:0]                       rdata_b,
  output logic                                        rvalid_b,
  output logic                                        fill_busy,
  output logic                                        fill_done,
  output logic                                        collision
);

  localparam int FIFO_WIDTH  = DATA_WIDTH * NUM_LANES;
  localparam int WORD_DEPTH  = MEM_DEPTH / NUM_LANES;
  localparam int ADDR_WIDTH  = $clog2(MEM_DEPTH);
  localparam int WADDR_WIDTH = $clog2(WORD_DEPTH);
  localparam int LANE_BITS   = glb_lane_bits(NUM_LANES);
  localparam logic [WADDR_WIDTH-1:0] LAST_WORD = WADDR_WIDTH'(WORD_DEPTH - 1);

  glb_fill_state_e               r_state;
  logic [WADDR_WIDTH-1:0]        r_ptr;
  logic [WADDR_WIDTH:0]          r_rem;
  logic [LANE_BITS-1:0]          r_lane_b;
  logic                          r_fwd;
  logic [DATA_WIDTH-1:0]         r_fwd_data;

  logic [WADDR_WIDTH-1:0]        w_addr_a;
  logic [WADDR_WIDTH-1:0]        w_word_b;
  logic [LANE_BITS-1:0]          w_lane_b;
  logic                          w_we_a;
  logic                          w_auto_acc;
  logic                          w_hit_ab;
  logic [DATA_WIDTH-1:0]         w_q_a [NUM_LANES];
  logic [DATA_WIDTH-1:0]         w_q_b [NUM_LANES];

  assign w_addr_a = a_auto ? r_ptr : addr_a;
  assign w_word_b = addr_b[ADDR_WIDTH-1:LANE_BITS];
  assign w_lane_b = addr_b[LANE_BITS-1:0];

  // Auto writes only land while a fill runs, and a same-cycle restart discards them.
  assign w_auto_acc = we_a & a_auto & (r_state == GLB_FILL_RUN) & ~fill_start;
  assign w_we_a     = (we_a & ~a_auto) | w_auto_acc;
  assign w_hit_ab   = w_we_a & wmask_a[w_lane_b] & (w_addr_a == w_word_b);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    glb_lane_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (WORD_DEPTH),
      .AW        (WADDR_WIDTH)
    ) u_ram (
      .clk      (clk),
      .rst      (rst),
      .i_we_a   (w_we_a & wmask_a[i]),
      .i_re_a   (re_a),
      .i_addr_a (w_addr_a),
      .i_wdata_a(wdata_a[glb_lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .o_rdata_a(w_q_a[i]),
      .i_we_b   (we_b & (w_lane_b == LANE_BITS'(i)) & ~w_hit_ab),
      .i_re_b   (re_b),
      .i_addr_b (w_word_b),
      .i_wdata_b(wdata_b),
      .o_rdata_b(w_q_b[i])
    );
    assign rdata_a[glb_lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = w_q_a[i];
  end

  // Lane select and forward flag only move on a read, so rdata_b holds between reads.
  assign rdata_b = r_fwd ? r_fwd_data : w_q_b[r_lane_b];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_a   <= 1'b0;
      rvalid_b   <= 1'b0;
      collision  <= 1'b0;
      r_lane_b   <= '0;
      r_fwd      <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      rvalid_a  <= re_a;
      rvalid_b  <= re_b;
      collision <= we_b & w_hit_ab;
      if (re_b) begin
        r_lane_b   <= w_lane_b;
        r_fwd      <= w_hit_ab;
        r_fwd_data <= wdata_a[w_lane_b*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= GLB_FILL_IDLE;
      r_ptr     <= '0;
      r_rem     <= '0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      if (fill_start) begin
        r_ptr <= fill_base;
        r_rem <= fill_len;
        if (fill_len != '0) begin
          r_state   <= GLB_FILL_RUN;
          fill_busy <= 1'b1;
        end else begin
          r_state   <= GLB_FILL_IDLE;
          fill_busy <= 1'b0;
          fill_done <= 1'b1;
        end
      end else if (w_auto_acc) begin
        r_ptr <= (r_ptr == LAST_WORD) ? '0 : r_ptr + 1'b1;
        r_rem <= r_rem - 1'b1;
        if (r_rem == (WADDR_WIDTH+1)'(1)) begin
          r_state   <= GLB_FILL_IDLE;
          fill_busy <= 1'b0;
          fill_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifmap_glb_banked.sv
// tb/tb_ifmap_glb_banked.sv - self-checking bench for ifmap_glb_banked against an element-array model
module tb_ifmap_glb_banked;

  localparam int DW = 16;
  localparam int NL = 4;
  localparam int MD = 64;
  localparam int WD = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          fill_start;
  logic [3:0]    fill_base;
  logic [4:0]    fill_len;
  logic          we_a;
  logic [3:0]    wmask_a;
  logic          a_auto;
  logic [3:0]    addr_a;
  logic [63:0]   wdata_a;
  logic          re_a;
  logic [63:0]   rdata_a;
  logic          rvalid_a;
  logic          we_b;
  logic          re_b;
  logic [5:0]    addr_b;
  logic [15:0]   wdata_b;
  logic [15:0]   rdata_b;
  logic          rvalid_b;
  logic          fill_busy;
  logic          fill_done;
  logic          collision;

  int tests = 0;
  int fails = 0;
  logic [15:0] m [MD];

  ifmap_glb_banked #(.DATA_WIDTH(DW), .NUM_LANES(NL), .MEM_DEPTH(MD)) dut (
    .clk(clk), .rst(rst), .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
    .we_a(we_a), .wmask_a(wmask_a), .a_auto(a_auto), .addr_a(addr_a), .wdata_a(wdata_a),
    .re_a(re_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a), .we_b(we_b), .re_b(re_b),
    .addr_b(addr_b), .wdata_b(wdata_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b),
    .fill_busy(fill_busy), .fill_done(fill_done), .collision(collision)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fill_start = 0; fill_base = 0; fill_len = 0; we_a = 0; wmask_a = 0; a_auto = 0;
    addr_a = 0; wdata_a = 0; re_a = 0; we_b = 0; re_b = 0; addr_b = 0; wdata_b = 0;
  endtask

  function automatic logic [63:0] model_word(input int w);
    logic [63:0] r;
    for (int i = 0; i < NL; i++) r[i*DW +: DW] = m[w*NL + i];
    return r;
  endfunction

  task automatic model_write(input int w, input logic [3:0] mask, input logic [63:0] d);
    for (int i = 0; i < NL; i++) if (mask[i]) m[w*NL + i] = d[i*DW +: DW];
  endtask

  task automatic wr_a(input int w, input logic [3:0] mask, input logic [63:0] d);
    we_a = 1; a_auto = 0; addr_a = 4'(w); wmask_a = mask; wdata_a = d;
    step();
    we_a = 0;
    model_write(w, mask, d);
  endtask

  task automatic rd_b(input int e, output logic [15:0] q, output logic v);
    re_b = 1; addr_b = 6'(e);
    step();
    re_b = 0; q = rdata_b; v = rvalid_b;
  endtask

  task automatic rd_a(input int w, output logic [63:0] q);
    re_a = 1; a_auto = 0; addr_a = 4'(w);
    step();
    re_a = 0; q = rdata_a;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    step(); step();
    tests++; if (rdata_a !== 64'h0) begin fails++; $display("FAIL reset_rdata_a got %h want 0", rdata_a); end
    tests++; if (rdata_b !== 16'h0) begin fails++; $display("FAIL reset_rdata_b got %h want 0", rdata_b); end
    tests++; if (rvalid_a !== 1'b0) begin fails++; $display("FAIL reset_rvalid_a got %b want 0", rvalid_a); end
    tests++; if (rvalid_b !== 1'b0) begin fails++; $display("FAIL reset_rvalid_b got %b want 0", rvalid_b); end
    tests++; if (fill_busy !== 1'b0) begin fails++; $display("FAIL reset_fill_busy got %b want 0", fill_busy); end
    tests++; if (fill_done !== 1'b0) begin fails++; $display("FAIL reset_fill_done got %b want 0", fill_done); end
    tests++; if (collision !== 1'b0) begin fails++; $display("FAIL reset_collision got %b want 0", collision); end
    rst = 0;
    step();
    for (int w = 0; w < WD; w++) wr_a(w, 4'hF, 64'h0);
  endtask

  task automatic test_fill();
    logic [15:0] q; logic v;
    int exp_e [3] = '{56, 60, 0};
    fill_start = 1; fill_base = 4'd14; fill_len = 5'd3;
    step();
    fill_start = 0;
    tests++; if (fill_busy !== 1'b1) begin fails++; $display("FAIL fill_busy_start got %b want 1", fill_busy); end
    for (int k = 0; k < 3; k++) begin
      we_a = 1; a_auto = 1; wmask_a = 4'hF;
      wdata_a = {16'(k+4), 16'(k+3), 16'(k+2), 16'(k+1)};
      model_write((14 + k) % WD, 4'hF, wdata_a);
      step();
      tests++;
      if (k < 2) begin
        if (fill_busy !== 1'b1 || fill_done !== 1'b0) begin
          fails++; $display("FAIL fill_mid k=%0d got busy=%b done=%b want busy=1 done=0", k, fill_busy, fill_done);
        end
      end else if (fill_busy !== 1'b0 || fill_done !== 1'b1) begin
        fails++; $display("FAIL fill_end got busy=%b done=%b want busy=0 done=1", fill_busy, fill_done);
      end
    end
    we_a = 0; a_auto = 0;
    step();
    tests++; if (fill_done !== 1'b0) begin fails++; $display("FAIL fill_done_pulse got %b want 0", fill_done); end
    for (int k = 0; k < 3; k++) begin
      rd_b(exp_e[k], q, v);
      tests++;
      if (q !== 16'(k+1) || q !== m[exp_e[k]] || v !== 1'b1) begin
        fails++; $display("FAIL fill_readback e=%0d got %h v=%b want %h v=1", exp_e[k], q, v, 16'(k+1));
      end
    end
  endtask

  task automatic test_mask_forward();
    logic [15:0] q; logic v;
    wr_a(5, 4'hF, {4{16'hAAAA}});
    we_a = 1; a_auto = 0; addr_a = 4'd5; wmask_a = 4'b0100;
    wdata_a = {16'h5555, 16'h1234, 16'h6666, 16'h7777};
    re_b = 1; addr_b = 6'd22;
    step();
    we_a = 0; re_b = 0;
    model_write(5, 4'b0100, {16'h5555, 16'h1234, 16'h6666, 16'h7777});
    tests++; if (rdata_b !== 16'h1234 || rvalid_b !== 1'b1) begin
      fails++; $display("FAIL forward got %h v=%b want 1234 v=1", rdata_b, rvalid_b); end
    rd_b(21, q, v);
    tests++; if (q !== 16'hAAAA) begin fails++; $display("FAIL mask_unwritten got %h want aaaa", q); end
    rd_b(22, q, v);
    tests++; if (q !== m[22]) begin fails++; $display("FAIL mask_stored got %h want %h", q, m[22]); end
  endtask

  task automatic test_collision();
    logic [15:0] q; logic v;
    for (int t = 0; t < 2; t++) begin
      we_a = 1; a_auto = 0; addr_a = 4'd2; wmask_a = 4'b0010; wdata_a = {16'h0, 16'h0, 16'h1111, 16'h0};
      we_b = 1; addr_b = (t == 0) ? 6'd9 : 6'd8; wdata_b = 16'h2222;
      step();
      we_a = 0; we_b = 0;
      m[9] = 16'h1111;
      if (t == 1) m[8] = 16'h2222;
      tests++; if (collision !== (t == 0)) begin
        fails++; $display("FAIL collision t=%0d got %b want %b", t, collision, t == 0); end
      step();
      tests++; if (collision !== 1'b0) begin fails++; $display("FAIL collision_pulse got %b want 0", collision); end
      rd_b(9, q, v);
      tests++; if (q !== 16'h1111) begin fails++; $display("FAIL collision_e9 t=%0d got %h want 1111", t, q); end
      rd_b(8, q, v);
      tests++; if (q !== m[8]) begin fails++; $display("FAIL collision_e8 t=%0d got %h want %h", t, q, m[8]); end
    end
  endtask

  task automatic test_read_first();
    logic [63:0] q;
    re_a = 1; addr_a = 4'd3; a_auto = 0;
    we_b = 1; addr_b = 6'd12; wdata_b = 16'hBEEF;
    step();
    re_a = 0; we_b = 0;
    tests++; if (rdata_a[15:0] !== 16'h0000 || rvalid_a !== 1'b1) begin
      fails++; $display("FAIL read_first got %h v=%b want 0000 v=1", rdata_a[15:0], rvalid_a); end
    m[12] = 16'hBEEF;
    rd_a(3, q);
    tests++; if (q[15:0] !== 16'hBEEF) begin fails++; $display("FAIL read_after got %h want beef", q[15:0]); end
  endtask

  task automatic test_fill_zero();
    logic [63:0] q;
    fill_start = 1; fill_base = 4'($urandom_range(0, 15)); fill_len = 5'd0;
    step();
    fill_start = 0;
    tests++; if (fill_done !== 1'b1 || fill_busy !== 1'b0) begin
      fails++; $display("FAIL fill_zero got done=%b busy=%b want done=1 busy=0", fill_done, fill_busy); end
    step();
    tests++; if (fill_done !== 1'b0 || fill_busy !== 1'b0) begin
      fails++; $display("FAIL fill_zero_after got done=%b busy=%b want 0 0", fill_done, fill_busy); end
    we_a = 1; a_auto = 1; wmask_a = 4'hF; wdata_a = {$urandom, $urandom};
    step();
    we_a = 0; a_auto = 0;
    for (int w = 0; w < WD; w++) begin
      rd_a(w, q);
      tests++; if (q !== model_word(w)) begin
        fails++; $display("FAIL idle_auto_write w=%0d got %h want %h", w, q, model_word(w)); end
    end
  endtask

  task automatic test_fill_random();
    logic [63:0] q;
    for (int it = 0; it < 4; it++) begin
      int base = $urandom_range(0, 15);
      int len  = $urandom_range(1, 6);
      int done_n = 0;
      fill_start = 1; fill_base = 4'(base); fill_len = 5'(len);
      step();
      fill_start = 0;
      for (int c = 0; c < 40 && done_n < len; c++) begin
        if ($urandom_range(0, 2) != 0) begin
          we_a = 1; a_auto = 1; wmask_a = 4'($urandom_range(1, 15)); wdata_a = {$urandom, $urandom};
          model_write((base + done_n) % WD, wmask_a, wdata_a);
          done_n++;
        end else begin
          we_a = 0;
        end
        step();
        we_a = 0; a_auto = 0;
        tests++;
        if (done_n == len) begin
          if (fill_done !== 1'b1 || fill_busy !== 1'b0) begin
            fails++; $display("FAIL rfill_end it=%0d got done=%b busy=%b want 1 0", it, fill_done, fill_busy); end
        end else if (fill_done !== 1'b0 || fill_busy !== 1'b1) begin
          fails++; $display("FAIL rfill_mid it=%0d got done=%b busy=%b want 0 1", it, fill_done, fill_busy);
        end
      end
      tests++; if (done_n != len) begin fails++; $display("FAIL rfill_budget it=%0d got %0d want %0d", it, done_n, len); end
      for (int w = 0; w < WD; w++) begin
        rd_a(w, q);
        tests++; if (q !== model_word(w)) begin
          fails++; $display("FAIL rfill_mem it=%0d w=%0d got %h want %h", it, w, q, model_word(w)); end
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    fill_start = 1; fill_base = 4'd0; fill_len = 5'd5;
    step();
    fill_start = 0;
    for (int k = 0; k < 2; k++) begin
      we_a = 1; a_auto = 1; wmask_a = 4'hF; wdata_a = {$urandom, $urandom};
      model_write(k, 4'hF, wdata_a);
      step();
    end
    we_a = 0; a_auto = 0;
    #2 rst = 1;
    #1;
    tests++; if (fill_busy !== 1'b0) begin fails++; $display("FAIL async_reset_busy got %b want 0", fill_busy); end
    step();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if (fill_done !== 1'b0 || fill_busy !== 1'b0) begin
        fails++; $display("FAIL reset_no_done got done=%b busy=%b want 0 0", fill_done, fill_busy); end
    end
  endtask

  task automatic test_random();
    logic [63:0] exp_ra = '0;
    logic [15:0] exp_rb = '0;
    for (int c = 0; c < 300; c++) begin
      logic ra, rb, wa, wb, hit, col;
      int aw, be;
      logic [3:0] mask;
      logic [63:0] wd;
      logic [15:0] bd;
      ra = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      rb = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      wa = 1'($urandom_range(0, 1));
      wb = 1'($urandom_range(0, 1));
      aw = $urandom_range(0, 3);
      be = $urandom_range(0, 15);
      mask = 4'($urandom);
      wd = {$urandom, $urandom};
      bd = 16'($urandom);
      hit = wa && mask[be % NL] && (aw == be / NL);
      col = wb && hit;
      if (ra) exp_ra = model_word(aw);
      if (rb) exp_rb = hit ? wd[(be % NL)*DW +: DW] : m[be];
      if (wa) model_write(aw, mask, wd);
      if (wb && !hit) m[be] = bd;
      we_a = wa; re_a = ra; a_auto = 0; addr_a = 4'(aw); wmask_a = mask; wdata_a = wd;
      we_b = wb; re_b = rb; addr_b = 6'(be); wdata_b = bd;
      step();
      tests++; if (rvalid_a !== ra || rvalid_b !== rb) begin
        fails++; $display("FAIL rnd_rvalid c=%0d got %b%b want %b%b", c, rvalid_a, rvalid_b, ra, rb); end
      tests++; if (collision !== col) begin
        fails++; $display("FAIL rnd_collision c=%0d got %b want %b", c, collision, col); end
      tests++; if (rdata_a !== exp_ra) begin
        fails++; $display("FAIL rnd_rdata_a c=%0d got %h want %h", c, rdata_a, exp_ra); end
      tests++; if (rdata_b !== exp_rb) begin
        fails++; $display("FAIL rnd_rdata_b c=%0d got %h want %h", c, rdata_b, exp_rb); end
    end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_mask_forward();
    test_collision();
    test_read_first();
    test_fill_zero();
    test_fill_random();
    test_reset_mid_fill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ifmap_glb_banked.md
Name: ifmap_glb_banked

Overview:
- Parametrised successor to the 4-lane ifmap global buffer: N-lane banked dual-port store.
- Port A is word-wide (NUM_LANES elements) on the FIFO/DRAM side, with per-lane write mask and an auto-increment fill engine.
- Port B is element-wide on the PE-array side; lane select is registered.
- Adds read-valid flags, cross-port write-to-read forwarding and write-collision arbitration.

Parameters:
- DATA_WIDTH, 16, element width in bits.
- NUM_LANES, 4, lanes per word; power of 2, at least 2.
- MEM_DEPTH, 64, total elements; multiple of NUM_LANES.
- Localparams: FIFO_WIDTH = DATA_WIDTH*NUM_LANES; WORD_DEPTH = MEM_DEPTH/NUM_LANES; ADDR_WIDTH = $clog2(MEM_DEPTH); WADDR_WIDTH = $clog2(WORD_DEPTH); LANE_BITS = $clog2(NUM_LANES).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- fill_start  in  1  load fill engine.
- fill_base  in  WADDR_WIDTH  first word of fill.
- fill_len  in  WADDR_WIDTH+1  words to fill.
- we_a  in  1  port A write.
- wmask_a  in  NUM_LANES  per-lane write enable.
- a_auto  in  1  1 = use fill pointer, 0 = use addr_a.
- addr_a  in  WADDR_WIDTH  port A word address.
- wdata_a  in  FIFO_WIDTH  lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- re_a  in  1  port A read.
- rdata_a  out  FIFO_WIDTH  port A read word.
- rvalid_a  out  1  rdata_a updated this cycle.
- we_b  in  1  port B write.
- re_b  in  1  port B read.
- addr_b  in  ADDR_WIDTH  element address; [LANE_BITS-1:0] = lane, upper bits = word.
- wdata_b  in  DATA_WIDTH  port B write element.
- rdata_b  out  DATA_WIDTH  port B read element.
- rvalid_b  out  1  rdata_b updated this cycle.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse at fill end.
- collision  out  1  one-cycle pulse: port B write dropped.

Behaviour:
- Reset values: rdata_a=0, rdata_b=0, rvalid_a=0, rvalid_b=0, fill_busy=0, fill_done=0, collision=0, fill pointer=0, remaining count=0. RAM contents are not reset. Async assert clears an in-flight fill and pending valids immediately.
- Port A effective word address = a_auto ? fill_ptr : addr_a.
- Port A write: lane i is written iff we_a & wmask_a[i]. A write with a_auto=1 while fill_busy=0 is dropped (no lane written).
- Read latency is 1 cycle on both ports. rvalid_x is high the cycle after re_x. rdata_x holds its last value when no read is issued.
- Same-port read+write to the same location: read-first (old data).
- Port A read vs same-cycle port B write to an element of that word: old data.
- Port B read vs same-cycle port A write covering that element (same word, mask bit set): forwarded; rdata_b = new wdata_a lane next cycle.
- Port B lane select uses addr_b lane bits registered alongside the read.
- Write collision (port A and port B write the same element in the same cycle): port A wins, port B write dropped, collision=1 next cycle. Different lanes of the same word do not collide.
- Fill FSM, states IDLE and FILL:
  - IDLE --fill_start, fill_len!=0--> FILL: ptr=fill_base, rem=fill_len.
  - IDLE --fill_start, fill_len==0--> IDLE, fill_done pulse next cycle.
  - FILL, each accepted auto write: ptr = (ptr+1) mod WORD_DEPTH (wraps to 0 at WORD_DEPTH-1); rem decrements.
  - On the write where rem becomes 0: -> IDLE, fill_busy=0 and fill_done=1 next cycle.
  - fill_start in FILL restarts: ptr and rem reload, no fill_done for the aborted fill.
  - fill_start with same-cycle auto write: start wins, the write is dropped.
  - fill_busy is high exactly in FILL.
- Manual writes (a_auto=0) are legal during FILL and do not advance the pointer.

Decomposition:
- Package glb_pkg: lane index/width helper functions; constant GLB_FILL_IDLE/GLB_FILL_RUN state encoding as a typedef enum; DATA_WIDTH default.
- One sub-module, glb_lane_ram: true dual-port RAM, WORD_DEPTH x DATA_WIDTH, per-port we/re, read-first, 1-cycle registered output holding value. Instantiated NUM_LANES times in a generate loop.
- Forwarding, collision and fill FSM live in the top level.

Test Plan:
- Reset then idle: rdata_a=0, rdata_b=0, all flags 0. Assert rst mid-fill (rem=3) -> fill_busy=0 immediately, no fill_done.
- Fill: fill_base=14, fill_len=3 (WORD_DEPTH=16), three auto writes of 0x0004_0003_0002_0001 (+1 per lane each word) -> words 14, 15, 0 written; fill_done pulses one cycle after the 3rd write; port B reads elements 56, 60, 0 -> 0x0001, 0x0002, 0x0003.
- Mask/forward: word 5 = 0xAAAA per lane. Port A writes word 5, wmask_a=0b0100, lane2=0x1234, while port B reads element 22 -> rdata_b=0x1234 next cycle, rvalid_b=1. Element 21 reads 0xAAAA.
- Collision: we_a word 2 lane 1 = 0x1111, we_b element 9 = 0x2222 same cycle -> collision=1 next cycle; element 9 reads 0x1111. Same test with element 8 -> no collision, both written.
- Read-first: port A reads word 3 (0x0000...) while port B writes element 12 = 0xBEEF -> rdata_a lane0=0x0000; the next read returns 0xBEEF.
- fill_len=0 -> fill_done next cycle, fill_busy stays 0. Auto write while idle -> memory unchanged.
